// File: rtl/nv_clk_gate_ctrl_if.sv
// Requester handshake bundle for the clock-gate controller: level req, registered ack.
interface nv_clk_gate_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/nv_clk_gate_ctrl.sv
// Idle-driven clk_en controller for one clock-gating cell, with idle hysteresis,
// wake settle latency, 4-phase requester acks and a saturating gate-event counter.
module nv_clk_gate_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int HYST_W   = 8,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    nv_clk_gate_ctrl_if.slave bus,
    input  logic              cfg_gate_en,
    input  logic              cfg_force_on,
    input  logic [HYST_W-1:0] cfg_idle_hyst,
    output logic              clk_en,
    output logic              gated,
    output logic [CNT_W-1:0]  gate_cnt,
    input  logic              gate_cnt_clr
);

    // One down-counter serves both HYST and WAKE, so it must fit the wider of the two loads.
    localparam int WL_W = ($clog2(WAKE_LAT) > 0) ? $clog2(WAKE_LAT) : 1;
    localparam int CW   = (HYST_W > WL_W) ? HYST_W : WL_W;
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_LAT - 1);

    typedef enum logic [1:0] {
        ON   = 2'd0,
        HYST = 2'd1,
        OFF  = 2'd2,
        WAKE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               idle, wake;
    logic [NUM_REQ-1:0] ack_nxt;
    logic               gate_inc;

    assign idle = ~|bus.req & cfg_gate_en & ~cfg_force_on;
    assign wake = ~idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ON;
            cnt      <= '0;
            bus.ack  <= '0;
            gate_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bus.ack <= ack_nxt;
            if (gate_cnt_clr)
                gate_cnt <= '0;
            else if (gate_inc && (gate_cnt != '1))
                gate_cnt <= gate_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ON: begin
                if (idle) begin
                    if (cfg_idle_hyst == '0) begin
                        state_nxt = OFF;
                    end else begin
                        state_nxt = HYST;
                        cnt_nxt   = CW'(cfg_idle_hyst - HYST_W'(1));
                    end
                end
            end
            HYST: begin
                if (wake)
                    state_nxt = ON;
                else if (cnt == '0)
                    state_nxt = OFF;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            OFF: begin
                if (wake) begin
                    state_nxt = WAKE;
                    cnt_nxt   = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Settle always runs to completion, even if every request drops meanwhile.
                if (cnt == '0)
                    state_nxt = ON;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            default: state_nxt = ON;
        endcase
    end

    always_comb begin
        clk_en   = (state != OFF);
        gated    = (state == OFF);
        ack_nxt  = bus.req & {NUM_REQ{(state == ON) || (state == HYST)}};
        gate_inc = (state_nxt == OFF) && (state != OFF);
    end

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Directed bench for nv_clk_gate_ctrl: idle-run/wake-timer model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_nv_clk_gate_ctrl;

    localparam int NUM_REQ  = 4;
    localparam int HYST_W   = 8;
    localparam int WAKE_LAT = 2;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_gate_en = 1'b1;
    logic              cfg_force_on = 1'b0;
    logic [HYST_W-1:0] cfg_idle_hyst = 8'd3;
    logic              gate_cnt_clr = 1'b0;
    logic              clk_en;
    logic              gated;
    logic [CNT_W-1:0]  gate_cnt;

    nv_clk_gate_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

    nv_clk_gate_ctrl #(
        .NUM_REQ (NUM_REQ),
        .HYST_W  (HYST_W),
        .WAKE_LAT(WAKE_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .cfg_gate_en  (cfg_gate_en),
        .cfg_force_on (cfg_force_on),
        .cfg_idle_hyst(cfg_idle_hyst),
        .clk_en       (clk_en),
        .gated        (gated),
        .gate_cnt     (gate_cnt),
        .gate_cnt_clr (gate_cnt_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: clock is off or running; running has an optional wake settle period
    // (wake_left > 0) and otherwise counts consecutive idle cycles against a
    // hysteresis value latched at the first idle cycle of the run.
    bit                 m_off = 1'b0;
    int                 m_wake_left = 0;
    int                 m_idle_run = 0;
    int                 m_hyst_lat = 0;
    logic [NUM_REQ-1:0] m_ack = '0;
    int                 m_gcnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_off = 1'b0; m_wake_left = 0; m_idle_run = 0; m_ack = '0; m_gcnt = 0;
        end else begin
            bit                 idle_now;
            bit                 gate_event;
            logic [NUM_REQ-1:0] nack;
            idle_now   = (bus.req == '0) && cfg_gate_en && !cfg_force_on;
            gate_event = 1'b0;
            nack       = '0;
            if (m_off) begin
                if (!idle_now) begin
                    m_off = 1'b0;
                    m_wake_left = WAKE_LAT;
                    m_idle_run = 0;
                end
            end else if (m_wake_left > 0) begin
                m_wake_left--;
            end else begin
                nack = bus.req;
                if (idle_now) begin
                    if (m_idle_run == 0) m_hyst_lat = int'(cfg_idle_hyst);
                    m_idle_run++;
                    if (m_idle_run > m_hyst_lat) begin
                        m_off = 1'b1;
                        m_idle_run = 0;
                        gate_event = 1'b1;
                    end
                end else begin
                    m_idle_run = 0;
                end
            end
            m_ack = nack;
            if (gate_cnt_clr) m_gcnt = 0;
            else if (gate_event && m_gcnt < CNT_MAX) m_gcnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clk_en", 32'(clk_en), 32'(!m_off));
            check("model_gated", 32'(gated), 32'(m_off));
            check("model_ack", 32'(bus.ack), 32'(m_ack));
            check("model_gate_cnt", 32'(gate_cnt), 32'(m_gcnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.req = '0;
        tick(2);
        // Reset state
        check("rst_clk_en", 32'(clk_en), 32'd1);
        check("rst_gated", 32'(gated), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_gate_cnt", 32'(gate_cnt), 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: hyst=3, idle from reset release: clk_en drops 4 cycles later
        tick(3);
        check("t1_still_on", 32'(clk_en), 32'd1);
        tick(1);
        check("t1_clk_en_off", 32'(clk_en), 32'd0);
        check("t1_gated", 32'(gated), 32'd1);
        check("t1_gate_cnt", 32'(gate_cnt), 32'd1);

        // 2: wake on req[2]; clk_en next cycle, ack 4 cycles after req
        bus.req = 4'b0100;
        tick(1);
        check("t2_clk_en_wake", 32'(clk_en), 32'd1);
        tick(2);
        check("t2_ack_early", 32'(bus.ack), 32'd0);
        tick(1);
        check("t2_ack", 32'(bus.ack), 32'b0100);

        // 3: hyst=5, req[0] re-raised on the HYST expiry cycle
        cfg_idle_hyst = 8'd5;
        bus.req = '0;
        tick(1);
        check("t3_ack_fall", 32'(bus.ack), 32'd0);
        tick(4);
        check("t3_before_expiry", 32'(clk_en), 32'd1);
        bus.req = 4'b0001;
        tick(1);
        check("t3_stays_on", 32'(clk_en), 32'd1);
        tick(3);
        check("t3_gate_cnt", 32'(gate_cnt), 32'd1);

        // 4: force_on from OFF wakes and holds; then gate_en=0 also holds
        bus.req = '0;
        tick(6);
        check("t4_off", 32'(gated), 32'd1);
        cfg_force_on = 1'b1;
        tick(1);
        check("t4_wake", 32'(clk_en), 32'd1);
        tick(20);
        check("t4_hold_force", 32'(clk_en), 32'd1);
        cfg_force_on = 1'b0;
        cfg_gate_en = 1'b0;
        tick(20);
        check("t4_hold_gate_dis", 32'(clk_en), 32'd1);
        check("t4_gate_cnt", 32'(gate_cnt), 32'd2);
        cfg_gate_en = 1'b1;

        // hysteresis value is latched at the ON->HYST load
        cfg_idle_hyst = 8'd3;
        tick(1);
        cfg_idle_hyst = 8'd0;
        tick(2);
        check("hyst_latched_on", 32'(clk_en), 32'd1);
        tick(1);
        check("hyst_latched_off", 32'(clk_en), 32'd0);

        // 5: async reset mid-WAKE
        bus.req = 4'b0010;
        tick(1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_clk_en", 32'(clk_en), 32'd1);
        check("t5_ack", 32'(bus.ack), 32'd0);
        check("t5_gate_cnt", 32'(gate_cnt), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check("t5_ack_after", 32'(bus.ack), 32'b0010);

        // 6: saturate gate_cnt, then clear wins over a same-cycle gate entry
        for (int i = 0; i < CNT_MAX + 7; i++) begin
            bus.req = '0;
            tick(1);
            bus.req = 4'b1000;
            tick(3);
        end
        check("t6_saturated", 32'(gate_cnt), 32'(CNT_MAX));
        bus.req = '0;
        gate_cnt_clr = 1'b1;
        tick(1);
        check("t6_clear_wins", 32'(gate_cnt), 32'd0);
        check("t6_gated", 32'(gated), 32'd1);
        gate_cnt_clr = 1'b0;
        bus.req = 4'b1000;
        tick(3);
        bus.req = '0;
        tick(1);
        check("t6_count_again", 32'(gate_cnt), 32'd1);

        tick(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
